// File: rtl/avl_arb_pkg.sv
// Shared types for the Avalon-ST packet arbiters.
//   - arb_state_e : arbiter FSM state (IDLE between packets, PKT while a
//                   grant is held from sop through eop).
//   - avl_data_t / avl_empty_t / avl_ch_t : stream field types for the
//                   default build (512-bit data, 4 inputs).
//   - PKT_CNT_W   : width of the output packet counter.
package avl_arb_pkg;

  localparam int AVL_DATA_W  = 512;
  localparam int AVL_N_IN    = 4;
  localparam int AVL_EMPTY_W = $clog2(AVL_DATA_W / 8);
  localparam int AVL_CH_W    = (AVL_N_IN > 1) ? $clog2(AVL_N_IN) : 1;
  localparam int PKT_CNT_W   = 32;

  typedef logic [AVL_DATA_W-1:0]  avl_data_t;
  typedef logic [AVL_EMPTY_W-1:0] avl_empty_t;
  typedef logic [AVL_CH_W-1:0]    avl_ch_t;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_PKT  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/avl_stream_pkt_arb_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req [N_IN]  : request vector.
//   ptr [PTR_W] : highest-priority index this cycle (always < N_IN).
//   idx [PTR_W] : first requester found scanning ptr, ptr+1, ... mod N_IN.
//   any         : at least one request is present (idx is 0 otherwise).
module rr_pick #(
  parameter int N_IN  = 4,
  parameter int PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic [N_IN-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [PTR_W-1:0] scan;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    scan = ptr;
    for (int i = 0; i < N_IN; i++) begin
      if (!any && req[scan]) begin
        any = 1'b1;
        idx = scan;
      end
      // Explicit wrap keeps the scan inside 0..N_IN-1 for any N_IN.
      scan = (scan == PTR_W'(N_IN - 1)) ? '0 : scan + 1'b1;
    end
  end

endmodule

// File: rtl/avl_stream_pkt_arb.sv
// avl_stream_pkt_arb: packet-granular round-robin merge of N_IN Avalon-ST
// streams onto one registered output stream. A grant is held from the sop
// beat through the eop beat, so packets never interleave.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset.
//   in_data/in_empty [N_IN]   : per-input beat payload / empty bytes.
//   in_valid/in_sop/in_eop    : per-input handshake and framing (bit per input).
//   in_ready                  : per-input accept (combinational, one-hot or 0).
//   out_data/out_empty        : registered output payload.
//   out_valid/out_ready       : output handshake.
//   out_sop/out_eop           : framing copied from the source beat.
//   out_channel               : index of the input the beat came from.
//   out_almost_full           : downstream hint, blocks new grants only when
//                               AVL_ARB_ALMOST_FULL_EN is defined.
//   pkt_cnt                   : eop beats handed downstream, wraps at 2^32.
// Build option: define AVL_ARB_ALMOST_FULL_EN to honour out_almost_full.
module avl_stream_pkt_arb
  import avl_arb_pkg::*;
#(
  parameter int WIDTH = AVL_DATA_W,
  parameter int N_IN  = AVL_N_IN,
  localparam int EMPTY_W = $clog2(WIDTH / 8),
  localparam int CH_W    = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data [N_IN],
  input  logic [N_IN-1:0]      in_valid,
  output logic [N_IN-1:0]      in_ready,
  input  logic [N_IN-1:0]      in_sop,
  input  logic [N_IN-1:0]      in_eop,
  input  logic [EMPTY_W-1:0]   in_empty [N_IN],
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic [EMPTY_W-1:0]   out_empty,
  output logic [CH_W-1:0]      out_channel,
  input  logic                 out_almost_full,
  output logic [PKT_CNT_W-1:0] pkt_cnt
);

  arb_state_e      state;
  logic [CH_W-1:0] gnt;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] pick;
  logic [CH_W-1:0] sel_p0;
  logic [N_IN-1:0] req;
  logic            pick_any;
  logic            grant_ok;
  logic            acc;
  logic            vld_p0;

  assign req = in_valid & in_sop;

  rr_pick #(
    .N_IN  (N_IN),
    .PTR_W (CH_W)
  ) u_rr_pick (
    .req (req),
    .ptr (rr_ptr),
    .idx (pick),
    .any (pick_any)
  );

`ifdef AVL_ARB_ALMOST_FULL_EN
  assign grant_ok = pick_any && !out_almost_full;
`else
  logic unused_af;
  assign unused_af = out_almost_full;
  assign grant_ok  = pick_any;
`endif

  // Input select: in_ready depends only on control, never on in_data.
  always_comb begin
    acc      = !out_valid || out_ready;
    sel_p0   = (state == ARB_PKT) ? gnt : pick;
    in_ready = '0;
    if (!rst && acc && ((state == ARB_PKT) || grant_ok))
      in_ready[sel_p0] = 1'b1;
    vld_p0   = in_valid[sel_p0] && in_ready[sel_p0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ARB_IDLE;
      rr_ptr <= '0;
      gnt    <= '0;
    end else if (vld_p0) begin
      if (state == ARB_IDLE) begin
        gnt    <= pick;
        rr_ptr <= (pick == CH_W'(N_IN - 1)) ? '0 : pick + 1'b1;
        // Single-beat packets release the grant immediately.
        if (!in_eop[sel_p0])
          state <= ARB_PKT;
      end else if (in_eop[sel_p0]) begin
        state <= ARB_IDLE;
      end
    end
  end

  // Output slot: reloads in the same cycle it drains, so no bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_empty   <= '0;
      out_channel <= '0;
      pkt_cnt     <= '0;
    end else begin
      if (acc)
        out_valid <= vld_p0;
      if (vld_p0) begin
        out_data    <= in_data[sel_p0];
        out_sop     <= in_sop[sel_p0];
        out_eop     <= in_eop[sel_p0];
        out_empty   <= in_empty[sel_p0];
        out_channel <= sel_p0;
      end
      if (out_valid && out_ready && out_eop)
        pkt_cnt <= pkt_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_avl_stream_pkt_arb.sv
module tb_avl_stream_pkt_arb;
  import avl_arb_pkg::*;

  localparam int WIDTH = AVL_DATA_W;
  localparam int N_IN  = AVL_N_IN;

  typedef struct {
    avl_data_t  data;
    logic       sop;
    logic       eop;
    avl_empty_t empty;
    avl_ch_t    ch;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [WIDTH-1:0]     in_data [N_IN];
  logic [N_IN-1:0]      in_valid;
  logic [N_IN-1:0]      in_ready;
  logic [N_IN-1:0]      in_sop;
  logic [N_IN-1:0]      in_eop;
  avl_empty_t           in_empty [N_IN];
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sop;
  logic                 out_eop;
  avl_empty_t           out_empty;
  avl_ch_t              out_channel;
  logic                 out_almost_full;
  logic [PKT_CNT_W-1:0] pkt_cnt;

  avl_stream_pkt_arb #(.WIDTH(WIDTH), .N_IN(N_IN)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_sop          (in_sop),
    .in_eop          (in_eop),
    .in_empty        (in_empty),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_sop         (out_sop),
    .out_eop         (out_eop),
    .out_empty       (out_empty),
    .out_channel     (out_channel),
    .out_almost_full (out_almost_full),
    .pkt_cnt         (pkt_cnt)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  beat_t      src_q[$];
  beat_t      exp_q[$];
  int         obs_ch[$];
  logic [N_IN-1:0] en;
  logic       toggle_rdy;
  int         model_cnt;
  logic       prev_stall;
  avl_data_t  hold_data;
  avl_ch_t    hold_ch;
  int         first_v, last_v, n_v;

  task automatic chk(string tag, logic [WIDTH-1:0] obs, logic [WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic avl_data_t rnd_data();
    avl_data_t d;
    for (int w = 0; w < WIDTH / 32; w++) d[32*w +: 32] = $urandom;
    return d;
  endfunction

  task automatic add_pkt(int p, int nbeats, int last_empty);
    beat_t b;
    for (int k = 0; k < nbeats; k++) begin
      b.data  = rnd_data();
      b.sop   = (k == 0);
      b.eop   = (k == nbeats - 1);
      b.empty = (k == nbeats - 1) ? avl_empty_t'(last_empty) : '0;
      b.ch    = avl_ch_t'(p);
      src_q.push_back(b);
    end
  endtask

  // Packs the observed channel order into a hex code (one nibble per beat).
  function automatic logic [63:0] seq_code();
    logic [63:0] c;
    c = '0;
    foreach (obs_ch[k]) c = (c << 4) | 64'(obs_ch[k]);
    return c;
  endfunction

  task automatic step();
    int         idx [N_IN];
    logic [N_IN-1:0] took;
    beat_t      b;
    int         mx, mp;
    if (toggle_rdy) out_ready = (cyc % 2) == 0;
    for (int p = 0; p < N_IN; p++) begin
      idx[p] = -1;
      for (int k = 0; k < src_q.size(); k++)
        if (idx[p] < 0 && src_q[k].ch == avl_ch_t'(p)) idx[p] = k;
      if (idx[p] >= 0 && en[p]) begin
        in_valid[p] = 1'b1;
        in_data[p]  = src_q[idx[p]].data;
        in_sop[p]   = src_q[idx[p]].sop;
        in_eop[p]   = src_q[idx[p]].eop;
        in_empty[p] = src_q[idx[p]].empty;
      end else begin
        in_valid[p] = 1'b0;
        in_data[p]  = '0;
        in_sop[p]   = 1'b0;
        in_eop[p]   = 1'b0;
        in_empty[p] = '0;
      end
    end
    #3;
    if (rst || (out_valid && !out_ready)) chk("ready_blocked", in_ready, '0);
    chk("ready_onehot0", $onehot0(in_ready), 1);
    if (prev_stall && !rst) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, hold_data);
      chk("stall_ch", out_channel, hold_ch);
    end
    prev_stall = !rst && out_valid && !out_ready;
    hold_data  = out_data;
    hold_ch    = out_channel;
    took = '0;
    for (int p = 0; p < N_IN; p++)
      if (in_valid[p] && in_ready[p]) begin
        took[p] = 1'b1;
        exp_q.push_back(src_q[idx[p]]);
      end
    if (out_valid) begin
      n_v++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
    if (out_valid && out_ready) begin
      chk("beat_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        chk("out_data", out_data, b.data);
        chk("out_sop", out_sop, b.sop);
        chk("out_eop", out_eop, b.eop);
        chk("out_empty", out_empty, b.empty);
        chk("out_channel", out_channel, b.ch);
      end
      obs_ch.push_back(int'(out_channel));
      if (out_eop) model_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int n = 0; n < N_IN; n++) begin
      mx = -1;
      mp = -1;
      for (int p = 0; p < N_IN; p++)
        if (took[p] && idx[p] > mx) begin
          mx = idx[p];
          mp = p;
        end
      if (mp >= 0) begin
        src_q.delete(mx);
        took[mp] = 1'b0;
      end
    end
  endtask

  task automatic drain(int maxc);
    int n;
    n = 0;
    while ((src_q.size() > 0 || out_valid || exp_q.size() > 0) && n < maxc) begin
      step();
      n++;
    end
    chk("drain_in_budget", n < maxc, 1);
  endtask

  task automatic start_scn();
    obs_ch.delete();
    first_v = -1;
    last_v  = -1;
    n_v     = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    src_q.delete();
    exp_q.delete();
    model_cnt  = 0;
    prev_stall = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    out_almost_full = 1'b0;
    toggle_rdy = 1'b0;
    en = '1;
    model_cnt = 0;
    prev_stall = 1'b0;
    for (int p = 0; p < N_IN; p++) begin
      in_data[p]  = rnd_data();
      in_empty[p] = '0;
    end
    in_valid = '1;
    in_sop   = '1;
    in_eop   = '0;
    // Reset state, with every input offering a sop.
    #3;
    chk("rst_in_ready", in_ready, '0);
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ctrl", {out_sop, out_eop, out_empty, out_channel}, 0);
    chk("rst_in_ready2", in_ready, '0);
    do_reset();

    // First sop on in2 shows up one cycle later on channel 2.
    start_scn();
    add_pkt(2, 2, 0);
    step();
    chk("lat_valid", out_valid, 1);
    chk("lat_channel", out_channel, 2);
    chk("lat_sop", out_sop, 1);
    drain(50);
    chk("s1_pkt_cnt", pkt_cnt, model_cnt);

    // All four inputs with 3-beat packets from rr_ptr=0.
    do_reset();
    start_scn();
    for (int p = 0; p < N_IN; p++) add_pkt(p, 3, 3 + p);
    drain(100);
    chk("s2_order", seq_code(), 64'h000111222333);
    chk("s2_len", obs_ch.size(), 12);
    chk("s2_valid_beats", n_v, 12);
    chk("s2_span", last_v - first_v + 1, 12);
    chk("s2_pkt_cnt", pkt_cnt, 4);

    // in0 raises sop while in1 is mid-packet: no interleaving.
    start_scn();
    add_pkt(1, 4, 7);
    add_pkt(0, 2, 1);
    en = 4'b0010;
    step();
    en = '1;
    drain(100);
    chk("s3_order", seq_code(), 64'h111100);
    chk("s3_pkt_cnt", pkt_cnt, model_cnt);

    // Move rr_ptr to 3, then single-beat packets on in3 and in0.
    add_pkt(2, 1, 9);
    drain(50);
    start_scn();
    add_pkt(3, 1, 5);
    add_pkt(0, 1, 17);
    drain(50);
    chk("s4_order", seq_code(), 64'h30);
    chk("s4_valid_beats", n_v, 2);
    chk("s4_span", last_v - first_v + 1, 2);
    chk("s4_pkt_cnt", pkt_cnt, model_cnt);

    // out_ready toggling mid-packet.
    start_scn();
    add_pkt(1, 4, 11);
    add_pkt(2, 2, 2);
    toggle_rdy = 1'b1;
    drain(200);
    toggle_rdy = 1'b0;
    out_ready = 1'b1;
    chk("s5_order", seq_code(), 64'h111122);
    chk("s5_pkt_cnt", pkt_cnt, model_cnt);
    chk("s5_pkt_cnt_abs", pkt_cnt, 11);

    // Reset mid-packet drops it and returns to IDLE.
    add_pkt(3, 4, 0);
    step();
    step();
    rst = 1'b1;
    out_ready = 1'b0;
    step();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_pkt_cnt", pkt_cnt, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    src_q.delete();
    exp_q.delete();
    model_cnt = 0;
    prev_stall = 1'b0;
    start_scn();
    add_pkt(1, 2, 4);
    drain(50);
    chk("s6_order", seq_code(), 64'h11);

`ifdef AVL_ARB_ALMOST_FULL_EN
    // Almost-full blocks new grants but not a packet in progress.
    start_scn();
    add_pkt(0, 3, 6);
    out_almost_full = 1'b1;
    step();
    step();
    step();
    chk("af_no_accept", src_q.size(), 3);
    chk("af_out_valid", out_valid, 0);
    out_almost_full = 1'b0;
    step();
    out_almost_full = 1'b1;
    drain(50);
    out_almost_full = 1'b0;
    chk("af_order", seq_code(), 64'h000);
`endif

    chk("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/avl_stream_pkt_arb.md
# avl_stream_pkt_arb

Packet-granular round-robin arbiter that merges N_IN Avalon-ST packet streams (512-bit data, sop/eop/empty framing) onto one output stream. A grant is held from the sop beat through the eop beat, so packets are never interleaved. The output channel field carries the index of the source input. The block sits in front of any shared single-stream consumer, such as a shared DMA or a single-port matcher, that is fed by per-port pipelines.

## Interface
- WIDTH, 512: data width in bits; empty width is $clog2(WIDTH/8).
- N_IN, 4: number of input streams; channel width is $clog2(N_IN), 1 bit minimum.
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- in_data[N_IN]  in  WIDTH  per-input beat data.
- in_valid[N_IN]  in  1  per-input beat valid.
- in_ready[N_IN]  out  1  per-input accept; a transfer occurs when in_valid && in_ready.
- in_sop[N_IN], in_eop[N_IN]  in  1  packet framing.
- in_empty[N_IN]  in  $clog2(WIDTH/8)  empty bytes on the eop beat.
- out_data  out  WIDTH  registered output data.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_sop, out_eop  out  1  framing, copied from the source beat.
- out_empty  out  $clog2(WIDTH/8)  copied from the source beat.
- out_channel  out  $clog2(N_IN)  index of the granted input.
- out_almost_full  in  1  downstream backpressure hint; used only under the macro below.
- pkt_cnt  out  32  count of eop beats transferred on the output; wraps at 2^32.

## Operation
- Output stage: one register slot holding data, valid, sop, eop, empty and channel.
  - The slot can accept a beat ("acc") when !out_valid || out_ready.
- States: IDLE and PKT. Registers: gnt[$clog2(N_IN)] and rr_ptr[$clog2(N_IN)].
- IDLE:
  - Requesters are inputs with in_valid && in_sop.
  - pick = first requester found searching rr_ptr, rr_ptr+1, … modulo N_IN.
  - in_ready[pick] = acc. All other in_ready = 0.
  - On transfer of the picked sop beat:
    - rr_ptr <= (pick+1) mod N_IN.
    - gnt <= pick.
    - If the beat is not eop, go to PKT. If it is eop (single-beat packet), stay in IDLE.
- PKT:
  - in_ready[gnt] = acc. All other in_ready = 0.
  - On transfer of the eop beat, go to IDLE.
  - An in_sop on a mid-packet beat is forwarded unchanged; no checking is done.
- In IDLE, a valid beat without sop on any input is never accepted. It stalls until a reset or a legal sop reaches the head of that input.
- out_channel is loaded with the index of the transferred input.
- pkt_cnt increments when out_valid && out_ready && out_eop.
- Modulo wrap: rr_ptr wraps from N_IN-1 to 0. For non-power-of-2 N_IN, rr_ptr never holds a value ≥ N_IN.

## Timing
- Reset values:
  - State IDLE; rr_ptr 0; gnt 0.
  - out_valid 0; out_data 0; out_sop 0; out_eop 0; out_empty 0; out_channel 0.
  - pkt_cnt 0; all in_ready 0 during rst.
- Latency: an input transfer in cycle t appears on out_* in cycle t+1.
- Throughput: 1 beat/cycle while out_ready=1, including back-to-back packets from different inputs. There is no bubble between the eop of one packet and the sop of the next.
- in_ready is combinational from in_valid/in_sop (IDLE only), out_valid and out_ready. There is no combinational path from in_data.
- When out_valid=1 and out_ready=0, all out_* hold stable and all in_ready = 0.
- Reset mid-packet drops the in-flight packet:
  - out_valid clears in the next cycle.
  - Upstream is responsible for resynchronising on sop.
- If the output consumes a beat and a new input beat arrives in the same cycle, the slot is reloaded with no gap.

## Configuration
- AVL_ARB_ALMOST_FULL_EN defined:
  - In IDLE, no new grant is issued while out_almost_full=1; all in_ready = 0.
  - A packet already granted (PKT state) continues regardless.
- AVL_ARB_ALMOST_FULL_EN undefined: out_almost_full is ignored (left unconnected internally).

## Structure
- Shared package avl_arb_pkg holds:
  - the state enum (IDLE, PKT);
  - the typedefs for the data, empty and channel widths, derived with the same formulas as the stream interface;
  - the localparam for the pkt_cnt width (32).
- One sub-module, rr_pick: a combinational round-robin picker.
  - Inputs: req[N_IN] and ptr.
  - Outputs: idx and any.
  - It is reused by the other arbiters in the design.
- The top level holds the FSM, the output register slot and the counter.

## Test plan
- Reset → out_valid=0, pkt_cnt=0, all in_ready=0; first sop on in2 → out_channel=2 one cycle later.
- in0..in3 all hold a 3-beat packet, out_ready=1 → output order ch 0,1,2,3; 12 consecutive valid beats; pkt_cnt=4.
- in1 sends a 4-beat packet while in0 asserts sop at beat 2 → all in1 beats are emitted contiguously, then in0; no interleaving.
- Single-beat packets (sop=eop=1) back-to-back on in3 and in0 with rr_ptr=3 → order 3,0; no idle cycle between them; empty values passed through.
- out_ready toggles 1/0 mid-packet → data is held stable while stalled; beats are neither lost nor duplicated; pkt_cnt counts only eop handshakes.
- With AVL_ARB_ALMOST_FULL_EN: out_almost_full=1 in IDLE → no sop is accepted; asserted during PKT → the packet completes; rst mid-PKT → out_valid=0 in the next cycle and state returns to IDLE.
